// File: rtl/ras_ctrl.sv
// Return-address-stack initiator: turns fetch call/ret hints and backend retire/mispredict
// events into RAS push/pop/commit/flush pulses. Optional counters under RAS_STATS_EN.
module ras_ctrl #(
    parameter int WIDTH        = 32,
    parameter int MAX_INFLIGHT = 16,
    parameter int INSN_BYTES   = 4
) (
    input  logic                              clk,
    input  logic                              rst_ni,
    input  logic                              fe_valid,
    input  logic                              fe_is_call,
    input  logic                              fe_is_ret,
    input  logic [WIDTH-1:0]                  fe_pc,
    output logic                              fe_ready,
    input  logic                              retire_valid,
    output logic                              retire_ready,
    input  logic                              mispredict,
    output logic                              ras_push,
    output logic                              ras_pop,
    output logic [WIDTH-1:0]                  ras_din,
    output logic                              ras_commit_push,
    output logic                              ras_commit_pop,
    output logic                              ras_flush,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              err_underflow,
    output logic [31:0]                       stat_commits,
    output logic [31:0]                       stat_flushes
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int PW = $clog2(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_FLUSH   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_q [MAX_INFLIGHT];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_push;
    logic             r_pop;
    logic [WIDTH-1:0] r_din;
    logic             r_cpush;
    logic             r_cpop;
    logic             r_flush;
    logic             r_err;

    logic       w_run;
    logic       w_full;
    logic       w_empty;
    logic       w_acc;
    logic       w_ret_acc;
    logic       w_flush_entry;
    logic [1:0] w_head;

    // Handshakes are held off during reset so nothing is accepted while rst_ni is low.
    assign w_run         = (r_state == S_RUN);
    assign w_full        = (r_count == CW'(MAX_INFLIGHT));
    assign w_empty       = (r_count == CW'(0));
    assign fe_ready      = rst_ni && w_run && !w_full;
    assign retire_ready  = rst_ni && w_run && !w_empty;
    assign w_acc         = fe_valid && fe_ready && (fe_is_call || fe_is_ret);
    assign w_ret_acc     = retire_valid && retire_ready;
    assign w_flush_entry = w_run && mispredict;
    assign w_head        = r_q[r_rptr];

    // In-flight op type storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_q[r_wptr] <= {fe_is_call, fe_is_ret};
        end
    end

    // Control FSM, queue pointers and registered RAS-facing pulses.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_state <= S_RUN;
            r_wptr  <= PW'(0);
            r_rptr  <= PW'(0);
            r_count <= CW'(0);
            r_push  <= 1'b0;
            r_pop   <= 1'b0;
            r_din   <= WIDTH'(0);
            r_cpush <= 1'b0;
            r_cpop  <= 1'b0;
            r_flush <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_push  <= 1'b0;
            r_pop   <= 1'b0;
            r_cpush <= 1'b0;
            r_cpop  <= 1'b0;
            r_flush <= 1'b0;
            if (w_acc) begin
                r_push <= fe_is_call;
                r_pop  <= fe_is_ret;
                r_wptr <= r_wptr + PW'(1);
                if (fe_is_call) begin
                    r_din <= fe_pc + WIDTH'(INSN_BYTES);
                end
            end
            if (w_ret_acc) begin
                r_cpush <= w_head[1];
                r_cpop  <= w_head[0];
                r_rptr  <= r_rptr + PW'(1);
            end
            case ({w_acc, w_ret_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (retire_valid && w_run && w_empty) begin
                r_err <= 1'b1;
            end
            // The FLUSH state discards everything queued, including an op accepted
            // alongside the mispredict, so its commit never reaches the RAS.
            case (r_state)
                S_RUN: begin
                    if (w_flush_entry) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_flush <= 1'b1;
                    r_wptr  <= PW'(0);
                    r_rptr  <= PW'(0);
                    r_count <= CW'(0);
                    r_state <= S_RECOVER;
                end
                S_RECOVER: r_state <= S_RUN;
                default:   r_state <= S_RUN;
            endcase
        end
    end

    assign ras_push        = r_push;
    assign ras_pop         = r_pop;
    assign ras_din         = r_din;
    assign ras_commit_push = r_cpush;
    assign ras_commit_pop  = r_cpop;
    assign ras_flush       = r_flush;
    assign inflight        = r_count;
    assign err_underflow   = r_err;

`ifdef RAS_STATS_EN
    logic [31:0] r_stat_commits;
    logic [31:0] r_stat_flushes;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_stat_commits <= 32'd0;
            r_stat_flushes <= 32'd0;
        end else begin
            if (w_ret_acc && (r_stat_commits != 32'hFFFF_FFFF)) begin
                r_stat_commits <= r_stat_commits + 32'd1;
            end
            if (w_flush_entry && (r_stat_flushes != 32'hFFFF_FFFF)) begin
                r_stat_flushes <= r_stat_flushes + 32'd1;
            end
        end
    end

    assign stat_commits = r_stat_commits;
    assign stat_flushes = r_stat_flushes;
`else
    assign stat_commits = 32'd0;
    assign stat_flushes = 32'd0;
`endif
endmodule
